// File: rtl/mem_arbiter.sv
// Shares one SRAM port between fetch and load/store. Grant is combinational, read data returns one cycle later.
// Only one port is granted per cycle. A denied port sees its stallreq and holds its request.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_INST = 2'd1,
        S_RD_DATA = 2'd2
    } state_t;

    localparam logic [2:0] LP_MAX_WAIT = 3'(MAX_WAIT);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_wait_cnt;

    logic w_conflict;
    logic w_inst_wins;
    logic w_inst_gnt;
    logic w_data_gnt;
    logic w_data_won;

    // Data normally wins a conflict; fetch is forced through once it has starved MAX_WAIT times.
    assign w_conflict  = inst_req & data_req;
    assign w_inst_wins = w_conflict & (r_wait_cnt == LP_MAX_WAIT);
    assign w_inst_gnt  = ~rst & inst_req & (~data_req | w_inst_wins);
    assign w_data_gnt  = ~rst & data_req & ~w_inst_wins;
    assign w_data_won  = w_conflict & ~w_inst_wins;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 3'd0;
        end else if (w_inst_gnt) begin
            r_wait_cnt <= 3'd0;
        end else if (w_data_won && (r_wait_cnt != LP_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The state records which port owns the SRAM read data arriving next cycle.
    always_comb begin
        w_next_state = S_IDLE;
        if (w_inst_gnt) begin
            w_next_state = S_RD_INST;
        end else if (w_data_gnt && (data_wen == 4'd0)) begin
            w_next_state = S_RD_DATA;
        end
    end

    always_comb begin
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
        data_rvalid = 1'b0;
        data_rdata  = 32'd0;
        case (r_state)
            S_RD_INST: begin
                inst_rvalid = 1'b1;
                inst_rdata  = sram_rdata;
            end
            S_RD_DATA: begin
                data_rvalid = 1'b1;
                data_rdata  = sram_rdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'd0;
        sram_addr  = 32'd0;
        sram_wdata = 32'd0;
        if (w_inst_gnt) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (w_data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    assign inst_gnt     = w_inst_gnt;
    assign data_gnt     = w_data_gnt;
    assign stallreq_if  = ~rst & inst_req & ~w_inst_gnt;
    assign stallreq_mem = ~rst & data_req & ~w_data_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized traffic.
// Stimulus pushes the expected read responses into a queue, and a monitor pops and checks them.
module tb_mem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata, sram_rdata;
    logic [3:0]  data_wen;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;
    logic        stallreq_if, stallreq_mem, sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;

    mem_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mw = 0;
    bit          mon_en = 0;
    logic [31:0] rd_pending = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ignt"}, 32'(inst_gnt), 32'd0);
        chk({nm, "_dgnt"}, 32'(data_gnt), 32'd0);
        chk({nm, "_en"}, 32'(sram_en), 32'd0);
        chk({nm, "_addr"}, sram_addr, 32'd0);
        chk({nm, "_wen"}, 32'(sram_wen), 32'd0);
        chk({nm, "_wdata"}, sram_wdata, 32'd0);
        chk({nm, "_stif"}, 32'(stallreq_if), 32'd0);
        chk({nm, "_stmem"}, 32'(stallreq_mem), 32'd0);
        chk({nm, "_irv"}, 32'(inst_rvalid), 32'd0);
        chk({nm, "_drv"}, 32'(data_rvalid), 32'd0);
        chk({nm, "_ird"}, inst_rdata, 32'd0);
        chk({nm, "_drd"}, data_rdata, 32'd0);
    endtask

    // Called at posedge+1; the call returns at posedge+1 of the following cycle.
    task automatic do_cycle(input logic ir, input logic [31:0] ia, input logic dr,
                            input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                            input logic [31:0] rd_next, output logic gi, output logic gd);
        logic ei, ed;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wen   = dw;
        data_addr  = da;
        data_wdata = dd;
        sram_rdata = rd_pending;
        rd_pending = rd_next;
        ei = ir && (!dr || mw == MAXW);
        ed = dr && !ei;
        @(negedge clk);
        chk("inst_gnt", 32'(inst_gnt), 32'(ei));
        chk("data_gnt", 32'(data_gnt), 32'(ed));
        chk("sram_en", 32'(sram_en), 32'(ei || ed));
        chk("sram_addr", sram_addr, ei ? ia : (ed ? da : 32'd0));
        chk("sram_wen", 32'(sram_wen), ed ? 32'(dw) : 32'd0);
        chk("sram_wdata", sram_wdata, ed ? dd : 32'd0);
        chk("stallreq_if", 32'(stallreq_if), 32'(ir && !ei));
        chk("stallreq_mem", 32'(stallreq_mem), 32'(dr && !ed));
        if (ei) q.push_back('{port: 1'b0, dat: rd_next, due: cyc + 1});
        if (ed && dw == 4'd0) q.push_back('{port: 1'b1, dat: rd_next, due: cyc + 1});
        if (ei) mw = 0;
        else if (ir && dr && mw < MAXW) mw = mw + 1;
        gi = inst_gnt;
        gd = data_gnt;
        @(posedge clk);
        cyc++;
        #1;
        chk("wait_cnt", 32'(dut.r_wait_cnt), 32'(mw));
    endtask

    // Monitor: every checked cycle either the queue head is due and must appear on its port, or no rvalid may show.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("rv_inst", 32'(inst_rvalid), 32'(!e.port));
                    chk("rv_data", 32'(data_rvalid), 32'(e.port));
                    chk("rv_rdata", e.port ? data_rdata : inst_rdata, e.dat);
                end else begin
                    chk("no_irv", 32'(inst_rvalid), 32'd0);
                    chk("no_drv", 32'(data_rvalid), 32'd0);
                end
                if (!inst_rvalid) chk("ird_idle", inst_rdata, 32'd0);
                if (!data_rvalid) chk("drd_idle", data_rdata, 32'd0);
            end
        end
    end

    initial begin
        logic gi, gd;
        logic ir, dr;
        logic [31:0] ia, da, dd;
        logic [3:0] dw;
        bit exp_d[6];
        int exp_w[6];
        exp_d = '{1, 1, 1, 1, 0, 1};
        exp_w = '{1, 2, 3, 4, 0, 1};

        rst = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; data_wen = 4'hF;
        inst_addr = 32'h1111_0000; data_addr = 32'h2222_0000;
        data_wdata = 32'hDEAD_BEEF; sram_rdata = 32'hFFFF_FFFF;
        #2;
        chk_all_zero("rst_req");
        chk("rst_wcnt", 32'(dut.r_wait_cnt), 32'd0);
        inst_req = 1'b0; data_req = 1'b0; data_wen = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        // Single fetch at the reset vector
        do_cycle(1, 32'hBFC0_0000, 0, 4'd0, 32'd0, 32'd0, 32'h3C1D_0001, gi, gd);
        sram_rdata = rd_pending;
        #1;
        chk("r17_irv", 32'(inst_rvalid), 32'd1);
        chk("r17_ird", inst_rdata, 32'h3C1D_0001);

        // Store against fetch: the store wins and produces no read response
        do_cycle(1, 32'hBFC0_0004, 1, 4'b0011, 32'h8000_0010, 32'h1234_ABCD, 32'hAAAA_0001, gi, gd);
        chk("r18_dgnt", 32'(gd), 32'd1);
        do_cycle(1, 32'hBFC0_0004, 0, 4'd0, 32'd0, 32'd0, 32'hAAAA_0002, gi, gd);
        chk("r18_igrant_after", 32'(gi), 32'd1);

        // Sustained conflict with loads
        for (int i = 0; i < 6; i++) begin
            do_cycle(1, 32'hBFC0_0100, 1, 4'd0, 32'h8000_0200, 32'd0, 32'h5000_0000 + 32'(i), gi, gd);
            chk("r19_dgnt", 32'(gd), 32'(exp_d[i]));
            chk("r19_wcnt", 32'(dut.r_wait_cnt), 32'(exp_w[i]));
        end
        do_cycle(1, 32'hBFC0_0100, 0, 4'd0, 32'd0, 32'd0, 32'h5000_0010, gi, gd);

        // Alternating single-port reads
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                do_cycle(1, 32'h0000_1000 + 32'(i * 4), 0, 4'd0, 32'd0, 32'd0, 32'hC000_0000 + 32'(i), gi, gd);
            else
                do_cycle(0, 32'd0, 1, 4'd0, 32'h0000_2000 + 32'(i * 4), 32'd0, 32'hD000_0000 + 32'(i), gi, gd);
        end

        // Load in flight, then reset asserted between clock edges
        do_cycle(0, 32'd0, 1, 4'd0, 32'h8000_0300, 32'd0, 32'h7777_0001, gi, gd);
        mon_en = 0;
        sram_rdata = rd_pending;
        #1;
        chk("r21_drv_before", 32'(data_rvalid), 32'd1);
        chk("r21_drd_before", data_rdata, 32'h7777_0001);
        #1;
        rst = 1'b1;
        #1;
        chk("r21_drv_rst", 32'(data_rvalid), 32'd0);
        chk("r21_drd_rst", data_rdata, 32'd0);
        q.delete();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        mw = 0;
        data_req = 1'b0;
        inst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("r21_post");
            @(posedge clk);
            cyc++;
        end
        #1;
        mon_en = 1;

        // Randomized traffic; a denied requester keeps its transaction until granted
        ir = 0; dr = 0; ia = 0; da = 0; dd = 0; dw = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ir || gi) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = $urandom;
            end
            if (!dr || gd) begin
                dr = ($urandom_range(0, 2) != 0);
                da = $urandom;
                dd = $urandom;
                dw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            do_cycle(ir, ia, dr, dw, da, dd, $urandom, gi, gd);
            gi = gi || !ir;
            gd = gd || !dr;
        end
        do_cycle(0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0, gi, gd);
        do_cycle(0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0, gi, gd);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
